// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Two-requester arbiter in front of a single UART TX path. A requester holds
//   valid with its byte; the arbiter grants one requester, captures its byte and
//   raises a start request toward the TX path. It then follows the TX path
//   through start acknowledge and busy before it arbitrates again.
//
//   Handshake: a requester asserts i_reqX_valid with i_reqX_data stable. The
//   byte is taken on the edge where the arbiter grants it, and o_reqX_ready
//   pulses for exactly one cycle after that edge. No request is queued, so a
//   valid dropped before its grant is simply never served. On the TX side,
//   o_tx_start stays high until i_tx_start_clear is sampled. The transfer then
//   ends on the first edge where i_tx_busy is low after busy has been seen
//   high at least once.
//
//   Optional feature: define UART_TX_ARB_TIMEOUT_EN to build an abort counter.
//   A transfer that stays in START+WAIT for TIMEOUT_CYC cycles is then dropped,
//   and o_timeout pulses. Without the macro, o_timeout is tied low and the
//   arbiter waits indefinitely.
//
// Parameters
//   TIMEOUT_CYC       abort limit in cycles (2..65535), only used with the macro
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   i_req0_valid/data requester 0 pending byte; o_req0_ready accept pulse
//   i_req1_valid/data requester 1 pending byte; o_req1_ready accept pulse
//   o_tx, o_tx_start  byte and start request to the TX path
//   i_tx_start_clear  TX path has taken the start request
//   i_tx_busy         TX path is serialising
//   o_grant           one-hot owner of the current transfer, 00 when idle
//   o_busy            arbiter not idle
//   o_timeout         one-cycle pulse when a transfer is aborted
module uart_tx_arb #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic [7:0] o_tx,
  output logic       o_tx_start,
  input  logic       i_tx_start_clear,
  input  logic       i_tx_busy,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT_CYC must be in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       seen_busy_q, seen_busy_d;
  logic       last_q, last_d;            // id of the last served/aborted owner
  logic [7:0] tx_q, tx_d;
  logic       tx_start_q, tx_start_d;
  logic       ready0_q, ready0_d;
  logic       ready1_q, ready1_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       pick;                      // 1 selects requester 1
  logic       owner;                     // id of the current owner
  logic       expire;                    // abort on this edge

  assign owner = grant_q[1];

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // The count sits at zero while idle, so it is zero at every grant edge and
  // counts the cycles spent in START+WAIT from there on.
  always_comb begin
    cnt_d = (state_q == ST_IDLE) ? 16'd0 : cnt_q + 16'd1;
  end

  assign expire = (state_q != ST_IDLE) && (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    last_d      = last_q;
    tx_d        = tx_q;
    tx_start_d  = tx_start_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    grant_d     = grant_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    pick        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((i_req0_valid || i_req1_valid) && !i_tx_busy) begin
          // On contention the requester not served last goes first.
          pick        = (i_req0_valid && i_req1_valid) ? ~last_q : i_req1_valid;
          state_d     = ST_START;
          tx_d        = pick ? i_req1_data : i_req0_data;
          tx_start_d  = 1'b1;
          ready0_d    = ~pick;
          ready1_d    = pick;
          grant_d     = pick ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          seen_busy_d = 1'b0;
        end
      end

      ST_START, ST_WAIT: begin
        if (expire) begin
          // Abort wins over a normal exit on the same edge.
          state_d     = ST_IDLE;
          tx_start_d  = 1'b0;
          grant_d     = 2'b00;
          busy_d      = 1'b0;
          timeout_d   = 1'b1;
          last_d      = owner;
          seen_busy_d = 1'b0;
        end else if (state_q == ST_START) begin
          if (i_tx_start_clear) begin
            tx_start_d  = 1'b0;
            state_d     = ST_WAIT;
            // Busy may already be up on the acknowledge edge.
            seen_busy_d = i_tx_busy;
          end
        end else begin
          // Only a busy that was seen high and then fell ends the transfer.
          if (seen_busy_q && !i_tx_busy) begin
            state_d     = ST_IDLE;
            grant_d     = 2'b00;
            busy_d      = 1'b0;
            last_d      = owner;
            seen_busy_d = 1'b0;
          end else if (i_tx_busy) begin
            seen_busy_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        tx_start_d  = 1'b0;
        grant_d     = 2'b00;
        busy_d      = 1'b0;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seen_busy_q <= 1'b0;
      last_q      <= 1'b1;               // requester 0 wins the first contention
      tx_q        <= 8'h00;
      tx_start_q  <= 1'b0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      tx_start_q  <= tx_start_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_req0_ready = ready0_q;
  assign o_req1_ready = ready1_q;
  assign o_tx         = tx_q;
  assign o_tx_start   = tx_start_q;
  assign o_grant      = grant_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Bench for uart_tx_arb with a behavioural TX-path driver. The reference model
//   is the arbitration rule itself: the winner is the only valid requester, or,
//   under contention, the one not served last. Each accepted byte is queued as
//   {grant, data} and matched when an accept pulse appears.
module tb_uart_tx_arb;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req0_valid, i_req1_valid;
  logic [7:0] i_req0_data, i_req1_data;
  logic       o_req0_ready, o_req1_ready;
  logic [7:0] o_tx;
  logic       o_tx_start;
  logic       i_tx_start_clear, i_tx_busy;
  logic [1:0] o_grant;
  logic       o_busy, o_timeout;

  always #5 clk = ~clk;

  uart_tx_arb #(.TIMEOUT_CYC(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req0_valid    (i_req0_valid),
    .i_req0_data     (i_req0_data),
    .o_req0_ready    (o_req0_ready),
    .i_req1_valid    (i_req1_valid),
    .i_req1_data     (i_req1_data),
    .o_req1_ready    (o_req1_ready),
    .o_tx            (o_tx),
    .o_tx_start      (o_tx_start),
    .i_tx_start_clear(i_tx_start_clear),
    .i_tx_busy       (i_tx_busy),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int LONG_BUSY = 2;   // keep the directed transfer inside the abort window
`else
  localparam int LONG_BUSY = 10;
`endif

  // ---------------- scoreboard state ----------------
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        last_srv;          // model: id of last served/aborted requester
  logic [9:0]  exp_q[$];          // expected {grant, byte} per accept, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Accept monitor: every ready pulse must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (o_req0_ready || o_req1_ready)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'({o_req1_ready, o_req0_ready}), 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("acc_grant", 32'(o_grant), 32'(e[9:8]));
        check("acc_tx", 32'(o_tx), 32'(e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n            = 1'b0;
    i_req0_valid     = 1'b0;
    i_req1_valid     = 1'b0;
    i_req0_data      = 8'h00;
    i_req1_data      = 8'h00;
    i_tx_start_clear = 1'b0;
    i_tx_busy        = 1'b0;
    #1;
    check("rst_tx", 32'(o_tx), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_ready", 32'({o_req1_ready, o_req0_ready}), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_srv = 1'b1;
    @(negedge clk);
  endtask

  // Present a request (optionally with the TX path busy for `pre` cycles first),
  // expect the accept one cycle after it becomes eligible, then withdraw it and
  // scramble the data to show the captured byte is unaffected.
  task automatic issue(input logic v0, input logic v1, input logic [7:0] d0,
                       input logic [7:0] d1, input int pre,
                       output logic win, output logic [7:0] wd);
    int waited;
    i_req0_valid = v0;
    i_req1_valid = v1;
    i_req0_data  = d0;
    i_req1_data  = d1;
    if (pre > 0) begin
      i_tx_busy = 1'b1;
      repeat (pre) begin
        @(negedge clk);
        check("busy_blocks_ready", 32'({o_req1_ready, o_req0_ready}), 32'd0);
        check("busy_blocks_grant", 32'(o_grant), 32'd0);
      end
      i_tx_busy = 1'b0;
    end
    win = (v0 && v1) ? ~last_srv : v1;
    wd  = win ? d1 : d0;
    exp_q.push_back({(win ? 2'b10 : 2'b01), wd});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(o_req0_ready || o_req1_ready) && waited < 20);
    check("accept_latency", 32'(waited), 32'd1);
    check("ready_onehot", 32'({o_req1_ready, o_req0_ready}), win ? 32'd2 : 32'd1);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_req0_data  = d0 ^ 8'hC3;
    i_req1_data  = d1 ^ 8'hC3;
  endtask

  // Full transfer: start acknowledged after k cycles, busy rises `gap` cycles
  // after the acknowledge and stays for blen cycles.
  task automatic run_xfer(input logic v0, input logic v1, input logic [7:0] d0,
                          input logic [7:0] d1, input int k, input int gap,
                          input int blen, input int pre);
    logic       win;
    logic [7:0] wd;
    issue(v0, v1, d0, d1, pre, win, wd);
    for (int j = 1; j <= k; j++) begin
      if (j > 1) begin
        @(negedge clk);
        check("ready_pulse", 32'({o_req1_ready, o_req0_ready}), 32'd0);
      end
      check("start_hold", 32'(o_tx_start), 32'd1);
      check("tx_hold", 32'(o_tx), 32'(wd));
    end
    i_tx_start_clear = 1'b1;
    if (gap == 0) i_tx_busy = 1'b1;
    @(negedge clk);
    i_tx_start_clear = 1'b0;
    check("start_drop", 32'(o_tx_start), 32'd0);
    check("ready_pulse", 32'({o_req1_ready, o_req0_ready}), 32'd0);
    check("wait_busy", 32'(o_busy), 32'd1);
    if (gap != 0) begin
      @(negedge clk);
      check("wait_before_busy", 32'(o_busy), 32'd1);
      i_tx_busy = 1'b1;
    end
    repeat (blen) begin
      @(negedge clk);
      check("wait_busy", 32'(o_busy), 32'd1);
      check("wait_grant", 32'(o_grant), win ? 32'd2 : 32'd1);
      check("tx_hold", 32'(o_tx), 32'(wd));
    end
    i_tx_busy = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_grant", 32'(o_grant), 32'd0);
    check("idle_tx_keep", 32'(o_tx), 32'(wd));
    check("idle_timeout", 32'(o_timeout), 32'd0);
    last_srv = win;
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Stall the transfer (in START, or in WAIT with busy stuck) and expect an abort
  // after 8 cycles out of idle.
  task automatic run_timeout(input logic v0, input logic v1, input logic [7:0] d0,
                             input logic [7:0] d1, input bit in_wait);
    logic       win;
    logic [7:0] wd;
    int         n_start;
    int         n_to;
    issue(v0, v1, d0, d1, 0, win, wd);
    n_start = 0;
    n_to    = 0;
    if (in_wait) begin
      i_tx_start_clear = 1'b1;
      i_tx_busy        = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (o_tx_start) n_start++;
      if (o_timeout)  n_to++;
      @(negedge clk);
      i_tx_start_clear = 1'b0;
    end
    check("to_start_cycles", 32'(n_start), in_wait ? 32'd1 : 32'd8);
    check("to_pulses", 32'(n_to), 32'd1);
    check("to_idle_busy", 32'(o_busy), 32'd0);
    check("to_idle_grant", 32'(o_grant), 32'd0);
    i_tx_busy = 1'b0;
    @(negedge clk);
    last_srv = win;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic       w;
    logic [7:0] wd;
    rst_n = 1'b1;
    #1;
    do_reset();

    // single request, start acknowledged after 2 cycles, long busy
    run_xfer(1'b1, 1'b0, 8'hA5, 8'h00, 2, 0, LONG_BUSY, 0);

    // contention straight after reset: req0, req1, req0
    do_reset();
    run_xfer(1'b1, 1'b1, 8'h11, 8'h22, 1, 0, 1, 0);
    run_xfer(1'b1, 1'b1, 8'h11, 8'h22, 2, 1, 1, 0);
    run_xfer(1'b1, 1'b1, 8'h11, 8'h22, 1, 0, 2, 0);

    // TX path busy blocks arbitration
    run_xfer(1'b0, 1'b1, 8'h00, 8'h5A, 1, 0, 1, 5);

    // data changes after the accept (3C becomes FF)
    run_xfer(1'b0, 1'b1, 8'h00, 8'h3C, 2, 0, 2, 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    run_timeout(1'b1, 1'b1, 8'h61, 8'h62, 1'b0);
    run_xfer(1'b1, 1'b1, 8'h63, 8'h64, 1, 0, 1, 0);
    run_timeout(1'b0, 1'b1, 8'h00, 8'h65, 1'b1);
    run_xfer(1'b1, 1'b1, 8'h66, 8'h67, 1, 0, 1, 0);
`else
    // no abort logic: start request is held as long as it takes
    run_xfer(1'b1, 1'b0, 8'h77, 8'h00, 20, 0, 2, 0);
`endif

    // reset in WAIT while requester 1 owns the transfer
    issue(1'b0, 1'b1, 8'h00, 8'h9E, 0, w, wd);
    i_tx_start_clear = 1'b1;
    i_tx_busy        = 1'b1;
    @(negedge clk);
    i_tx_start_clear = 1'b0;
    check("mid_grant", 32'(o_grant), 32'd2);
    #2;
    do_reset();
    run_xfer(1'b1, 1'b1, 8'h44, 8'h55, 1, 0, 1, 0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int v;
      v = int'($urandom_range(1, 3));
      run_xfer(v[0], v[1], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(1, 2)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
